// File: rtl/vmem_pkg.sv
// Shared widths, object-layout helpers and sweep FSM encoding for the VPU object memory.
package vmem_pkg;

   localparam int ADDR_W_DEF   = 5;
   localparam int COORD_W_DEF  = 16;
   localparam int NUM_VERT_DEF = 4;
   localparam int COLOR_W_DEF  = 12;
   localparam int TYPE_W_DEF   = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } vmem_state_e;

   function automatic int obj_width(input int num_vert, input int coord_w,
                                    input int color_w, input int type_w);
      return 2 * num_vert * coord_w + color_w + type_w;
   endfunction

   function automatic int x_off(input int i, input int coord_w);
      return 2 * i * coord_w;
   endfunction

   function automatic int y_off(input int i, input int coord_w);
      return (2 * i + 1) * coord_w;
   endfunction

   function automatic int color_off(input int num_vert, input int coord_w);
      return 2 * num_vert * coord_w;
   endfunction

   function automatic int type_off(input int num_vert, input int coord_w, input int color_w);
      return 2 * num_vert * coord_w + color_w;
   endfunction

endpackage

// File: rtl/vmem_obj_unpack.sv
// Combinational slicer: packed object word -> vertex x/y, colour and type fields.
module vmem_obj_unpack
   import vmem_pkg::*;
#(
   parameter  int COORD_W  = COORD_W_DEF,
   parameter  int NUM_VERT = NUM_VERT_DEF,
   parameter  int COLOR_W  = COLOR_W_DEF,
   parameter  int TYPE_W   = TYPE_W_DEF,
   localparam int OBJ_W    = obj_width(NUM_VERT, COORD_W, COLOR_W, TYPE_W)
) (
   input  logic [OBJ_W-1:0]            obj,
   output logic [NUM_VERT*COORD_W-1:0] x,
   output logic [NUM_VERT*COORD_W-1:0] y,
   output logic [COLOR_W-1:0]          color,
   output logic [TYPE_W-1:0]           obj_type
);

   for (genvar i = 0; i < NUM_VERT; i++) begin : g_vert
      assign x[i*COORD_W +: COORD_W] = obj[x_off(i, COORD_W) +: COORD_W];
      assign y[i*COORD_W +: COORD_W] = obj[y_off(i, COORD_W) +: COORD_W];
   end

   assign color    = obj[color_off(NUM_VERT, COORD_W) +: COLOR_W];
   assign obj_type = obj[type_off(NUM_VERT, COORD_W, COLOR_W) +: TYPE_W];

endmodule

// File: rtl/video_obj_mem.sv
// VPU object store with valid bitmap, clear sweep and three registered read paths.
// Define VMEM_WR_BYPASS_EN for write-first forwarding on the clip and loadback paths.
module video_obj_mem
   import vmem_pkg::*;
#(
   parameter  int ADDR_W   = ADDR_W_DEF,
   parameter  int COORD_W  = COORD_W_DEF,
   parameter  int NUM_VERT = NUM_VERT_DEF,
   parameter  int COLOR_W  = COLOR_W_DEF,
   parameter  int TYPE_W   = TYPE_W_DEF,
   localparam int OBJ_W    = obj_width(NUM_VERT, COORD_W, COLOR_W, TYPE_W)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           mat_addr,
   input  logic [OBJ_W-1:0]            mat_obj_in,
   input  logic                        mat_wr_en,
   input  logic                        mat_rd_en,
   input  logic                        loadback,
   input  logic [ADDR_W-1:0]           clip_addr,
   input  logic                        clip_rd_en,
   input  logic                        clear_all,
   output logic [OBJ_W-1:0]            mat_obj_out,
   output logic                        mat_obj_valid,
   output logic [OBJ_W-1:0]            clip_obj_out,
   output logic                        clip_obj_valid,
   output logic [NUM_VERT*COORD_W-1:0] ldback_x,
   output logic [NUM_VERT*COORD_W-1:0] ldback_y,
   output logic [COLOR_W-1:0]          ldback_color,
   output logic [TYPE_W-1:0]           ldback_type,
   output logic                        ldback_valid,
   output logic                        clear_busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   vmem_state_e       state;
   vmem_state_e       state_next;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] cnt_idx;
   logic              sweep_last;
   logic              sweep_wr;
   logic              wr_acc;
   logic              clip_fwd;
   logic              lb_fwd;

   logic [OBJ_W-1:0]  ram [DEPTH];
   logic [DEPTH-1:0]  valid;

   logic [OBJ_W-1:0]  mat_word;
   logic              mat_v;
   logic [OBJ_W-1:0]  clip_word;
   logic              clip_v;
   logic [OBJ_W-1:0]  lb_word;
   logic              lb_v;

   logic [NUM_VERT*COORD_W-1:0] lb_x;
   logic [NUM_VERT*COORD_W-1:0] lb_y;
   logic [COLOR_W-1:0]          lb_color;
   logic [TYPE_W-1:0]           lb_type;

   assign cnt_idx    = cnt[ADDR_W-1:0];
   assign sweep_last = (cnt == CNT_W'(DEPTH - 1));
   assign sweep_wr   = (state == CLEAR) && !rst;
   assign wr_acc     = (state == IDLE) && mat_wr_en && !rst;

`ifdef VMEM_WR_BYPASS_EN
   assign clip_fwd = wr_acc && (clip_addr == mat_addr);
   assign lb_fwd   = wr_acc;
`else
   assign clip_fwd = 1'b0;
   assign lb_fwd   = 1'b0;
`endif

   // Sweep FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (clear_all) state_next = CLEAR;
            else           state_next = IDLE;
         end
         CLEAR: begin
            if (sweep_last) state_next = IDLE;
            else            state_next = CLEAR;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sweep state, counter and busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         clear_busy <= 1'b0;
      end else begin
         state      <= state_next;
         clear_busy <= (state_next == CLEAR);
         if (state == IDLE) cnt <= '0;
         else               cnt <= cnt + CNT_W'(1);
      end
   end

   // Object storage; contents survive reset, the sweep zeroes them
   always_ff @(posedge clk) begin
      if (sweep_wr)    ram[cnt_idx]  <= '0;
      else if (wr_acc) ram[mat_addr] <= mat_obj_in;
   end

   // Per-entry valid bitmap
   always_ff @(posedge clk) begin
      if (rst)           valid           <= '0;
      else if (sweep_wr) valid[cnt_idx]  <= 1'b0;
      else if (wr_acc)   valid[mat_addr] <= 1'b1;
   end

   // Read muxes: invalid entries read as zero, optional write forwarding
   always_comb begin
      mat_word  = '0;
      clip_word = '0;
      lb_word   = '0;
      mat_v     = valid[mat_addr];
      clip_v    = valid[clip_addr];
      lb_v      = valid[mat_addr];
      if (mat_v) mat_word = ram[mat_addr];
      else       mat_word = '0;
      if (clip_fwd) begin
         clip_word = mat_obj_in;
         clip_v    = 1'b1;
      end else if (clip_v) begin
         clip_word = ram[clip_addr];
      end else begin
         clip_word = '0;
      end
      if (lb_fwd) begin
         lb_word = mat_obj_in;
         lb_v    = 1'b1;
      end else if (lb_v) begin
         lb_word = ram[mat_addr];
      end else begin
         lb_word = '0;
      end
   end

   vmem_obj_unpack #(
      .COORD_W  (COORD_W),
      .NUM_VERT (NUM_VERT),
      .COLOR_W  (COLOR_W),
      .TYPE_W   (TYPE_W)
   ) u_unpack (
      .obj      (lb_word),
      .x        (lb_x),
      .y        (lb_y),
      .color    (lb_color),
      .obj_type (lb_type)
   );

   // Registered read outputs, holding while their strobe is low
   always_ff @(posedge clk) begin
      if (rst) begin
         mat_obj_out    <= '0;
         mat_obj_valid  <= 1'b0;
         clip_obj_out   <= '0;
         clip_obj_valid <= 1'b0;
         ldback_x       <= '0;
         ldback_y       <= '0;
         ldback_color   <= '0;
         ldback_type    <= '0;
         ldback_valid   <= 1'b0;
      end else begin
         if (mat_rd_en) begin
            mat_obj_out   <= mat_word;
            mat_obj_valid <= mat_v;
         end
         if (clip_rd_en) begin
            clip_obj_out   <= clip_word;
            clip_obj_valid <= clip_v;
         end
         if (loadback) begin
            ldback_x     <= lb_x;
            ldback_y     <= lb_y;
            ldback_color <= lb_color;
            ldback_type  <= lb_type;
            ldback_valid <= lb_v;
         end
      end
   end

endmodule

// File: tb/tb_video_obj_mem.sv
// Scoreboard bench for video_obj_mem: directed scenarios plus randomized traffic vs a behavioural model.
module tb_video_obj_mem;

   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int OW    = 144;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          v;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] mat_addr, clip_addr;
   logic [OW-1:0] mat_obj_in;
   logic          mat_wr_en, mat_rd_en, loadback, clip_rd_en, clear_all;
   logic [OW-1:0] mat_obj_out, clip_obj_out;
   logic          mat_obj_valid, clip_obj_valid, ldback_valid, clear_busy;
   logic [63:0]   ldback_x, ldback_y;
   logic [11:0]   ldback_color;
   logic [3:0]    ldback_type;

   video_obj_mem dut (
      .clk(clk), .rst(rst), .mat_addr(mat_addr), .mat_obj_in(mat_obj_in),
      .mat_wr_en(mat_wr_en), .mat_rd_en(mat_rd_en), .loadback(loadback),
      .clip_addr(clip_addr), .clip_rd_en(clip_rd_en), .clear_all(clear_all),
      .mat_obj_out(mat_obj_out), .mat_obj_valid(mat_obj_valid),
      .clip_obj_out(clip_obj_out), .clip_obj_valid(clip_obj_valid),
      .ldback_x(ldback_x), .ldback_y(ldback_y), .ldback_color(ldback_color),
      .ldback_type(ldback_type), .ldback_valid(ldback_valid), .clear_busy(clear_busy)
   );

   always #5 clk = ~clk;

   // behavioural model: contents, valid flags, sweep position (-1 when no sweep)
   logic [OW-1:0] mem [DEPTH];
   bit            vld [DEPTH];
   int            pos = -1;
   rd_exp_t       last_mat, last_clip, last_lb;

   rd_exp_t q_mat[$], q_clip[$], q_lb[$];
   bit      q_busy[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [OW:0] got, input logic [OW:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic rd_exp_t model_read(input logic [AW-1:0] a);
      rd_exp_t r;
      r.v    = vld[a];
      r.data = vld[a] ? mem[a] : '0;
      return r;
   endfunction

   // one clock of stimulus: drive at negedge, predict, push expectations, advance model
   task automatic cycle(input logic r, input logic wr, input logic mrd, input logic lb,
                        input logic crd, input logic clr, input logic [AW-1:0] ma,
                        input logic [AW-1:0] ca, input logic [OW-1:0] din);
      bit wacc;
      @(negedge clk);
      rst = r; mat_wr_en = wr; mat_rd_en = mrd; loadback = lb; clip_rd_en = crd;
      clear_all = clr; mat_addr = ma; clip_addr = ca; mat_obj_in = din;
      if (r) begin
         last_mat = '0; last_clip = '0; last_lb = '0;
         for (int i = 0; i < DEPTH; i++) vld[i] = 1'b0;
         pos = -1;
      end else begin
         wacc = (pos < 0) && wr;
         if (mrd) last_mat = model_read(ma);
         if (crd) last_clip = model_read(ca);
         if (lb)  last_lb = model_read(ma);
`ifdef VMEM_WR_BYPASS_EN
         if (crd && wacc && ca == ma) last_clip = '{data: din, v: 1'b1};
         if (lb && wacc) last_lb = '{data: din, v: 1'b1};
`endif
         if (pos >= 0) begin
            mem[pos] = '0;
            vld[pos] = 1'b0;
            pos = (pos == DEPTH - 1) ? -1 : pos + 1;
         end else if (clr) begin
            pos = 0;
         end
         if (wacc) begin
            mem[ma] = din;
            vld[ma] = 1'b1;
         end
      end
      q_mat.push_back(last_mat);
      q_clip.push_back(last_clip);
      q_lb.push_back(last_lb);
      q_busy.push_back(pos >= 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, '0, '0, '0);
   endtask

   function automatic logic [OW-1:0] rnd_obj();
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return w[OW-1:0];
   endfunction

   // monitor: compare every output one cycle after its stimulus
   initial begin
      rd_exp_t      e;
      logic [OW-1:0] lbw;
      forever begin
         @(posedge clk);
         #1;
         if (q_mat.size() > 0) begin
            e = q_mat.pop_front();
            chk("mat_read", {mat_obj_out, mat_obj_valid}, {e.data, e.v});
         end
         if (q_clip.size() > 0) begin
            e = q_clip.pop_front();
            chk("clip_read", {clip_obj_out, clip_obj_valid}, {e.data, e.v});
         end
         if (q_lb.size() > 0) begin
            e = q_lb.pop_front();
            for (int i = 0; i < 4; i++) begin
               lbw[2*i*16 +: 16]     = ldback_x[i*16 +: 16];
               lbw[(2*i+1)*16 +: 16] = ldback_y[i*16 +: 16];
            end
            lbw[128 +: 12] = ldback_color;
            lbw[140 +: 4]  = ldback_type;
            chk("loadback", {lbw, ldback_valid}, {e.data, e.v});
         end
         if (q_busy.size() > 0) begin
            chk("clear_busy", {{OW{1'b0}}, clear_busy}, {{OW{1'b0}}, q_busy.pop_front()});
         end
      end
   end

   initial begin
      logic [OW-1:0] obj3;
      logic [OW-1:0] ones, twos;
      rst = 1'b1; mat_wr_en = 1'b0; mat_rd_en = 1'b0; loadback = 1'b0;
      clip_rd_en = 1'b0; clear_all = 1'b0; mat_addr = '0; clip_addr = '0; mat_obj_in = '0;
      last_mat = '0; last_clip = '0; last_lb = '0;

      cycle(1, 0, 0, 0, 0, 0, '0, '0, '0);
      cycle(1, 0, 0, 0, 0, 0, '0, '0, '0);

      // read of never-written entry after reset
      cycle(0, 0, 1, 1, 1, 0, 5'd7, 5'd7, '0);

      // field layout through loadback
      obj3 = '0;
      for (int i = 0; i < 8; i++) obj3[i*16 +: 16] = 16'(16'h0011 * (i + 1));
      obj3[128 +: 12] = 12'hABC;
      obj3[140 +: 4]  = 4'h5;
      cycle(0, 1, 0, 0, 0, 0, 5'd3, '0, obj3);
      cycle(0, 0, 0, 1, 0, 0, 5'd3, '0, '0);
      idle(1);

      // same-cycle write and read of addr 2
      ones = {36{4'h1}};
      twos = {36{4'h2}};
      cycle(0, 1, 0, 0, 0, 0, 5'd2, '0, twos);
      cycle(0, 1, 1, 1, 1, 0, 5'd2, 5'd2, ones);
      cycle(0, 0, 1, 0, 1, 0, 5'd2, 5'd2, '0);

      // fill, sweep, mid-sweep read, dropped write, ignored re-trigger
      for (int a = 0; a < DEPTH; a++) cycle(0, 1, 0, 0, 0, 0, AW'(a), '0, rnd_obj());
      cycle(0, 0, 0, 0, 0, 1, '0, '0, '0);
      idle(4);
      cycle(0, 0, 1, 1, 1, 0, 5'd31, 5'd31, '0);
      cycle(0, 1, 0, 0, 0, 0, 5'd0, '0, ones);
      cycle(0, 0, 0, 0, 0, 1, '0, '0, '0);
      idle(30);
      cycle(0, 0, 1, 1, 1, 0, 5'd31, 5'd0, '0);

      // reset in the middle of a sweep
      for (int a = 0; a < DEPTH; a++) cycle(0, 1, 0, 0, 0, 0, AW'(a), '0, rnd_obj());
      cycle(0, 0, 0, 0, 0, 1, '0, '0, '0);
      idle(9);
      cycle(1, 0, 0, 0, 0, 0, '0, '0, '0);
      cycle(0, 0, 1, 0, 1, 0, 5'd20, 5'd30, '0);
      cycle(0, 1, 0, 0, 0, 0, 5'd1, '0, twos);
      cycle(0, 0, 1, 1, 1, 0, 5'd1, 5'd1, '0);

      // randomized traffic with address collisions, rare clears and resets
      for (int n = 0; n < 1500; n++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 9) < 4,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 49) == 0,
               ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3)),
               rnd_obj());
      end

      @(posedge clk);
      #3;
      chk("queues_drained", (OW+1)'(q_mat.size() + q_clip.size() + q_lb.size() + q_busy.size()),
          (OW+1)'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_obj_mem.md
Name: video_obj_mem

Overview:
Parametrised object store for the VPU. It holds DEPTH packed objects: NUM_VERT vertices plus colour and object type.
- Matrix-side port: one read/write address, with write, read and loadback operations.
- Clip-side port: read-only.
- Additions over the previous object memory:
  - per-entry valid bitmap;
  - a sequential clear sweep;
  - loadback of every field, including colour and type;
  - valid flags on every output.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
COORD_W, 16, width of one x or y coordinate
NUM_VERT, 4, vertices per object
COLOR_W, 12, colour field width
TYPE_W, 4, object-type field width
OBJ_W, derived = 2*NUM_VERT*COORD_W + COLOR_W + TYPE_W (144 at defaults); not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mat_addr  in  ADDR_W  matrix-side address, shared by write, read and loadback
mat_obj_in  in  OBJ_W  write data
mat_wr_en  in  1  write strobe
mat_rd_en  in  1  matrix read strobe
loadback  in  1  field-unpacked read strobe
clip_addr  in  ADDR_W  clip-side address
clip_rd_en  in  1  clip read strobe
clear_all  in  1  start-sweep pulse
mat_obj_out  out  OBJ_W  matrix read data
mat_obj_valid  out  1  valid bit of the entry read on the matrix port
clip_obj_out  out  OBJ_W  clip read data
clip_obj_valid  out  1  valid bit of the entry read on the clip port
ldback_x  out  NUM_VERT*COORD_W  x of vertex i at [i*COORD_W +: COORD_W]
ldback_y  out  NUM_VERT*COORD_W  y of vertex i, same packing
ldback_color  out  COLOR_W  colour field
ldback_type  out  TYPE_W  object-type field
ldback_valid  out  1  valid bit of the loadback entry
clear_busy  out  1  high while the sweep runs

Behaviour:
- Object layout:
  - vertex i x at [2i*COORD_W +: COORD_W];
  - vertex i y at [(2i+1)*COORD_W +: COORD_W];
  - colour at [2*NUM_VERT*COORD_W +: COLOR_W];
  - type at the top TYPE_W bits.
- Reset:
  - all outputs, the valid bitmap and the sweep counter go to 0;
  - FSM goes to IDLE;
  - RAM contents are not cleared.
  - Reset asserted mid-sweep aborts the sweep and forces IDLE.
- Write: mat_wr_en in IDLE writes ram[mat_addr] and sets valid[mat_addr] at the same edge.
- Reads:
  - Every read path (mat, clip, loadback) has 1-cycle latency: registered at the edge where its enable is sampled.
  - Each output holds its value while its enable is low.
  - A read of an entry whose valid bit is 0 returns all-zero data with the matching *_valid = 0.
  - mat_rd_en, loadback and clip_rd_en may all be asserted in the same cycle; each is served independently.
- Read-during-write to the same address, on either port, is read-first: the read returns the old data and old valid bit.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_all; counter loads 0.
  - In CLEAR, each cycle writes zero to ram[cnt], clears valid[cnt] and increments cnt.
  - At cnt = DEPTH-1 the FSM returns to IDLE on the next edge.
- clear_busy timing: high exactly DEPTH cycles, starting the cycle after clear_all is sampled.
- clear_all while in CLEAR: ignored, no restart.
- mat_wr_en during CLEAR: dropped silently. Requesters must check clear_busy before writing.
- Reads during CLEAR:
  - allowed;
  - entries not yet swept return their old data with valid 1;
  - swept entries return zero with valid 0.
- Counter: ADDR_W+1 bits, so no wrap hazard at DEPTH-1.

Optional Feature:
VMEM_WR_BYPASS_EN
- Defined: a clip or loadback read to the same address as an accepted mat_wr_en in the same cycle returns mat_obj_in with valid = 1 (write-first forwarding).
- Undefined: these reads are read-first, as above.
- mat_obj_out is read-first in both builds.

Decomposition:
- Package vmem_pkg holds:
  - width defaults;
  - derived OBJ_W and field-offset functions;
  - the FSM state enum (IDLE, CLEAR).
- Sub-module vmem_obj_unpack: combinational slicer from an OBJ_W word to x/y/colour/type fields. Used on the loadback path.

Test Plan:
- Write addr 3 with x0=0x0011, y0=0x0022, …, y3=0x0088, colour=0xABC, type=0x5; then loadback addr 3 -> next cycle every field matches, ldback_valid=1.
- After reset, mat read and clip read of addr 7 -> zero data, both *_valid=0.
- Same cycle: write addr 2 with 0x1..1, clip read addr 2 (old data 0x2..2) -> clip_obj_out=0x2..2 without the macro, 0x1..1 with VMEM_WR_BYPASS_EN.
- Fill all 32 entries, pulse clear_all, then read addr 31 on cycle 5 of the sweep -> old data with valid 1, clear_busy high exactly 32 cycles.
- After the sweep completes, read addr 31 -> zero data, valid 0.
- During the sweep: write addr 0 -> dropped; a second clear_all -> no restart.
- Assert rst at sweep cycle 10 -> clear_busy=0 next cycle, all valid bits 0; a subsequent write and read of addr 1 works normally.
